// File: rtl/float_div_seq.sv
// float_div_seq: sequential floating-point divider (result = op1 / op2).
// Custom format {sign, exponent, mantissa}: bias 2^(N_EXP-1)-1, exponent 0 means zero,
// no NaN/inf/denormals. Out-of-range results saturate to {sign, EMAX, all ones}.
// The quotient is computed by restoring division, one bit per cycle, MSB first.
// The result is truncated; there is no rounding.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   operands presented (accepted only while in_ready)
//   in_ready   high only in the idle state
//   op1, op2   dividend and divisor
//   out_valid  result available; held until out_ready
//   out_ready  consumer takes result
//   result     quotient
//   div_zero   op2 was zero; valid while out_valid
module float_div_seq #(
  parameter int unsigned N_MANT = 23,
  parameter int unsigned N_EXP  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_EXP+N_MANT:0]   op1,
  input  logic [N_EXP+N_MANT:0]   op2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_EXP+N_MANT:0]   result,
  output logic                    div_zero
);

  localparam int unsigned W  = 1 + N_EXP + N_MANT;
  localparam int unsigned EW = N_EXP + 2;          // signed exponent working width
  localparam int unsigned RW = N_MANT + 2;         // remainder / quotient width
  localparam int unsigned CW = $clog2(N_MANT + 3);

  localparam logic signed [EW-1:0] Bias    = EW'((1 << (N_EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EmaxS   = EW'((1 << N_EXP) - 2);
  localparam logic signed [EW-1:0] ExpOne  = EW'(1);
  localparam logic [N_EXP-1:0]     EmaxE   = N_EXP'((1 << N_EXP) - 2);
  localparam logic [CW-1:0]        CntLoad = CW'(N_MANT + 2);
  localparam logic [CW-1:0]        CntOne  = CW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

  state_t r_state, w_state_next;

  logic                 r_sign;
  logic                 r_zero1;
  logic                 r_zero2;
  logic signed [EW-1:0] r_exp;
  logic [RW-1:0]        r_rem;
  logic [N_MANT:0]      r_div;
  logic [RW-2:0]        r_quo;
  logic [CW-1:0]        r_cnt;
  logic [W-1:0]         r_result;
  logic                 r_div_zero;

  // Operand fields
  logic [N_EXP-1:0]     w_e1, w_e2;
  logic [N_MANT-1:0]    w_m1, w_m2;
  logic signed [EW-1:0] w_exp_acc;

  assign w_e1 = op1[W-2 -: N_EXP];
  assign w_e2 = op2[W-2 -: N_EXP];
  assign w_m1 = op1[N_MANT-1:0];
  assign w_m2 = op2[N_MANT-1:0];
  assign w_exp_acc = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + Bias;

  // One restoring-division step
  logic                 w_ge;
  logic [RW-1:0]        w_rem_sel;
  logic [RW-1:0]        w_rem_next;
  logic [RW-1:0]        w_q;
  logic                 w_last;
  logic signed [EW-1:0] w_exp_adj;
  logic [N_MANT-1:0]    w_mant;
  logic [W-1:0]         w_res;
  logic                 w_dz;

  assign w_ge       = r_rem >= {1'b0, r_div};
  assign w_rem_sel  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
  // Remainder after a step is below the divisor, so the shift never loses a set bit.
  assign w_rem_next = w_rem_sel << 1;
  assign w_q        = {r_quo, w_ge};
  assign w_last     = (r_cnt == CntOne);

  // Quotient in (0.5, 2): normalise by one position when the integer bit is clear.
  assign w_exp_adj  = w_q[RW-1] ? r_exp : (r_exp - ExpOne);
  assign w_mant     = w_q[RW-1] ? w_q[N_MANT:1] : w_q[N_MANT-1:0];

  always_comb begin
    w_res = {r_sign, {(W-1){1'b0}}};
    w_dz  = r_zero2;
    if (r_zero2) begin
      if (!r_zero1) w_res = {r_sign, EmaxE, {N_MANT{1'b1}}};
    end else if (r_zero1) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp_adj[EW-1] || (w_exp_adj == '0)) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp_adj > EmaxS) begin
      w_res = {r_sign, EmaxE, {N_MANT{1'b1}}};
    end else begin
      w_res = {r_sign, w_exp_adj[N_EXP-1:0], w_mant};
    end
  end

  // FSM
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_next = StCalc;
      StCalc:  if (w_last)    w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default:                w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign     <= 1'b0;
      r_zero1    <= 1'b0;
      r_zero2    <= 1'b0;
      r_exp      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (r_state == StIdle) begin
      if (in_valid) begin
        r_sign  <= op1[W-1] ^ op2[W-1];
        r_zero1 <= (w_e1 == '0);
        r_zero2 <= (w_e2 == '0);
        r_exp   <= w_exp_acc;
        r_rem   <= {1'b0, 1'b1, w_m1};
        r_div   <= {1'b1, w_m2};
        r_quo   <= '0;
        r_cnt   <= CntLoad;
      end
    end else if (r_state == StCalc) begin
      r_rem <= w_rem_next;
      r_quo <= w_q[RW-2:0];
      r_cnt <= r_cnt - CntOne;
      if (w_last) begin
        r_result   <= w_res;
        r_div_zero <= w_dz;
      end
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_float_div_seq.sv
// Bench for float_div_seq (N_EXP=8, N_MANT=23): vector table through a scoreboard queue,
// plus hand-written stall and mid-operation reset sequences.
module tb_float_div_seq;

  localparam int W   = 32;
  localparam int LAT = 25;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         div_zero;

  always #5 clk = ~clk;

  float_div_seq #(
    .N_MANT(23),
    .N_EXP (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .div_zero (div_zero)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dz;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (called with the DUT idle) and record the expectation.
  task automatic accept(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input logic dz);
    exp_t e;
    check({name, " in_ready"}, W'(in_ready), 1);
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    e.name = name;
    e.res  = res;
    e.dz   = dz;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
  endtask

  // Wait (bounded) for out_valid, check latency, pop and compare.
  task automatic wait_done(output exp_t got);
    int lat;
    lat = 0;
    got.name = "none";
    got.res  = '0;
    got.dz   = 1'b0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      check("scoreboard empty", W'(sb.size()), 1);
    end else begin
      got = sb.pop_front();
      check({got.name, " latency"}, W'(lat), LAT);
      check({got.name, " out_valid"}, W'(out_valid), 1);
      check({got.name, " result"}, result, got.res);
      check({got.name, " div_zero"}, W'(div_zero), W'(got.dz));
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " idle in_ready"}, W'(in_ready), 1);
    check({name, " idle out_valid"}, W'(out_valid), 0);
  endtask

  vec_t vecs[$];

  initial begin
    exp_t got;
    int   seen;

    vecs = '{
      '{"6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 1'b0},
      '{"1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0},
      '{"overflow",   32'h7F7FFFFF, 32'h3F000000, 32'h7F7FFFFF, 1'b0},
      '{"underflow",  32'h0D800000, 32'h71800000, 32'h00000000, 1'b0},
      '{"x/0",        32'hC0400000, 32'h00000000, 32'hFF7FFFFF, 1'b1},
      '{"0/0",        32'h00000000, 32'h00000000, 32'h00000000, 1'b1},
      '{"1/1",        32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0},
      '{"-1/2",       32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0},
      '{"7/2",        32'h40E00000, 32'h40000000, 32'h40600000, 1'b0},
      '{"3/1.5",      32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0},
      '{"1/1.5",      32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0},
      '{"0/-2",       32'h00000000, 32'hC0000000, 32'h80000000, 1'b0},
      '{"0m/2",       32'h00123456, 32'h40000000, 32'h00000000, 1'b0},
      '{"5/-0",       32'h40A00000, 32'h80000000, 32'hFF7FFFFF, 1'b1},
      '{"emax",       32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0},
      '{"emin",       32'h00800000, 32'h3F800000, 32'h00800000, 1'b0},
      '{"e0 after -1",32'h00800000, 32'h3FC00000, 32'h00000000, 1'b0}
    };

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1       = '0;
    op2       = '0;
    tick();
    tick();
    check("reset in_ready", W'(in_ready), 1);
    check("reset out_valid", W'(out_valid), 0);
    check("reset result", result, 0);
    check("reset div_zero", W'(div_zero), 0);

    // Reset wins over in_valid: no operation may start.
    in_valid = 1'b1;
    op1      = 32'h40C00000;
    op2      = 32'h40000000;
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    seen     = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("reset vs in_valid no output", W'(seen), 0);

    // Vector table
    foreach (vecs[i]) begin
      accept(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);
      wait_done(got);
      release_out(vecs[i].name);
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    accept("stall", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    wait_done(got);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op1      = 32'h40C00000;
      op2      = 32'h40000000;
      tick();
      check("stall result", result, 32'h3EAAAAAA);
      check("stall out_valid", W'(out_valid), 1);
      check("stall in_ready", W'(in_ready), 0);
    end
    in_valid = 1'b0;
    release_out("stall");
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("stall pulses ignored", W'(seen), 0);

    // Reset in the 10th CALC cycle discards the operation.
    accept("abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("abort still busy", W'(in_ready), 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    check("abort in_ready", W'(in_ready), 1);
    check("abort out_valid", W'(out_valid), 0);
    check("abort result", result, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort no output", W'(seen), 0);

    accept("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    wait_done(got);
    release_out("after abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
